// File: rtl/chacha_pkg.sv
// Shared constants and types for the ChaCha keystream XOR stage.
package chacha_pkg;

  localparam int CHACHA_WORD_W  = 32;
  localparam int CHACHA_BLOCK_W = 512;
  localparam int CHACHA_WORDS   = 16;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BLK,
    STREAM
  } ks_state_e;

  typedef logic [CHACHA_WORD_W-1:0] chacha_word_t;

endpackage

// File: rtl/chacha_out_reg.sv
// Single-entry valid/ready output register carrying one result word and its last flag.
module chacha_out_reg
  import chacha_pkg::*;
#(
  parameter int WIDTH = $bits(chacha_word_t)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last
);

  // A load wins over a drain so one word per cycle flows without a bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
      out_last  <= in_last;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/chacha_keystream_xor.sv
// Keystream XOR stage: latches a 512-bit ChaCha block and XORs its words into a message stream.
// Macro CHACHA_KS_PREFETCH_EN adds a spare block buffer so consecutive blocks chain without a bubble.
module chacha_keystream_xor
  import chacha_pkg::*;
#(
  parameter int WORD_WIDTH      = CHACHA_WORD_W,
  parameter int BLOCK_WIDTH     = CHACHA_BLOCK_W,
  parameter int WORDS_PER_BLOCK = BLOCK_WIDTH / WORD_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  output logic                   blk_req,
  input  logic                   blk_valid,
  input  logic [BLOCK_WIDTH-1:0] blk_data,
  output logic                   blk_ready,
  input  logic                   msg_valid,
  input  logic [WORD_WIDTH-1:0]  msg_data,
  input  logic                   msg_last,
  output logic                   msg_ready,
  output logic                   out_valid,
  output logic [WORD_WIDTH-1:0]  out_data,
  output logic                   out_last,
  input  logic                   out_ready,
  output logic                   busy
);

  localparam int IDX_W = $clog2(CHACHA_WORDS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_BLOCK - 1);

  ks_state_e              state, state_next;
  logic [IDX_W-1:0]       idx;
  logic [BLOCK_WIDTH-1:0] blk_buf;
  logic                   xfer, load_blk, req_next;
  logic [WORD_WIDTH-1:0]  ks_word;

  assign msg_ready = (state == STREAM) && (!out_valid || out_ready);
  assign xfer      = msg_valid && msg_ready;
  assign busy      = (state != IDLE);
  assign ks_word   = blk_buf[int'(idx) * WORD_WIDTH +: WORD_WIDTH];

`ifdef CHACHA_KS_PREFETCH_EN
  logic [BLOCK_WIDTH-1:0] spare_buf;
  logic spare_full, outstanding, fill_spare, swap, stream_ready, want_req;

  assign stream_ready = (state == STREAM) && !spare_full;
  assign blk_ready    = (state == WAIT_BLK) || stream_ready;
  // A block arriving with the final word of the current one goes straight to the active buffer.
  assign fill_spare   = stream_ready && blk_valid && !(xfer && (msg_last || idx == LAST_IDX));
  assign want_req     = (state == STREAM) && !spare_full && !fill_spare && !outstanding &&
                        !blk_req && !(xfer && msg_last);
`else
  assign blk_ready = (state == WAIT_BLK);
`endif

  always_comb begin
    state_next = state;
    req_next   = 1'b0;
    load_blk   = 1'b0;
`ifdef CHACHA_KS_PREFETCH_EN
    swap       = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (msg_valid) begin
          state_next = WAIT_BLK;
          req_next   = 1'b1;
        end
      end
      WAIT_BLK: begin
        if (blk_valid) begin
          load_blk   = 1'b1;
          state_next = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (msg_last) begin
            state_next = IDLE;
          end else if (idx == LAST_IDX) begin
`ifdef CHACHA_KS_PREFETCH_EN
            if (spare_full)     swap       = 1'b1;
            else if (blk_valid) load_blk   = 1'b1;
            else                state_next = WAIT_BLK;
`else
            state_next = WAIT_BLK;
            req_next   = 1'b1;
`endif
          end
        end
      end
      default: state_next = IDLE;
    endcase
`ifdef CHACHA_KS_PREFETCH_EN
    if (want_req) req_next = 1'b1;
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      idx     <= '0;
      blk_buf <= '0;
      blk_req <= 1'b0;
    end else begin
      state   <= state_next;
      blk_req <= req_next;
      if (load_blk) begin
        blk_buf <= blk_data;
        idx     <= '0;
`ifdef CHACHA_KS_PREFETCH_EN
      end else if (swap) begin
        blk_buf <= spare_buf;
        idx     <= '0;
`endif
      end else if (xfer) begin
        idx <= idx + 1'b1;
      end
    end
  end

`ifdef CHACHA_KS_PREFETCH_EN
  // Tracks a request still in flight so the spare is asked for exactly once.
  always_ff @(posedge clk) begin
    if (!reset) begin
      spare_buf   <= '0;
      spare_full  <= 1'b0;
      outstanding <= 1'b0;
    end else begin
      outstanding <= (outstanding || blk_req) && !(blk_valid && blk_ready);
      if (fill_spare) begin
        spare_buf  <= blk_data;
        spare_full <= 1'b1;
      end else if (swap || (xfer && msg_last)) begin
        spare_full <= 1'b0;
      end
    end
  end
`endif

  chacha_out_reg #(.WIDTH(WORD_WIDTH)) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (xfer),
    .in_data   (msg_data ^ ks_word),
    .in_last   (msg_last),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last)
  );

endmodule

// File: tb/tb_chacha_keystream_xor.sv
// Directed bench for chacha_keystream_xor; a small behavioural core answers block requests.
module tb_chacha_keystream_xor;
  import chacha_pkg::*;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      blk_req, blk_valid, blk_ready;
  logic [CHACHA_BLOCK_W-1:0] blk_data;
  logic                      msg_valid, msg_last, msg_ready;
  chacha_word_t              msg_data, out_data;
  logic                      out_valid, out_last, out_ready, busy;

  int passes = 0, fails = 0, total = 0;
  int req_count = 0, pending = 0, run_len = 0, max_run = 0, base = 0;
  bit got_req, took, rst_now;
  logic [CHACHA_BLOCK_W-1:0] blk_q[$];
  logic [32:0]               got_q[$];
  logic [CHACHA_BLOCK_W-1:0] blk;

  always #5 clk = ~clk;

  chacha_keystream_xor dut (
    .clk(clk), .reset(reset), .blk_req(blk_req), .blk_valid(blk_valid), .blk_data(blk_data),
    .blk_ready(blk_ready), .msg_valid(msg_valid), .msg_data(msg_data), .msg_last(msg_last),
    .msg_ready(msg_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  // Behavioural core: one queued block is offered per request, held until accepted.
  initial begin
    blk_valid = 1'b0;
    blk_data  = '0;
    forever begin
      @(negedge clk);
      got_req = (blk_req === 1'b1);
      took    = (blk_valid === 1'b1) && (blk_ready === 1'b1);
      rst_now = (reset !== 1'b1);
      if (got_req) req_count++;
      @(posedge clk);
      #1;
      if (rst_now) begin
        blk_valid = 1'b0;
        pending   = 0;
      end else begin
        if (got_req) pending++;
        if (took) blk_valid = 1'b0;
        if (!blk_valid && pending > 0 && blk_q.size() > 0) begin
          blk_data  = blk_q.pop_front();
          blk_valid = 1'b1;
          pending--;
        end
      end
    end
  end

  // Output monitor: records accepted words and the longest run of out_valid cycles.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1)
        got_q.push_back({out_last, out_data});
      if (out_valid === 1'b1) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [CHACHA_BLOCK_W-1:0] makeBlock(input chacha_word_t first);
    logic [CHACHA_BLOCK_W-1:0] b;
    b = '0;
    for (int i = 0; i < CHACHA_WORDS; i++) b[32*i +: 32] = first + 32'(i);
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkWord(input string tag, input chacha_word_t exp_data, input logic exp_last);
    logic [32:0] obs;
    obs = 'x;
    if (got_q.size() > 0) obs = got_q.pop_front();
    checkOutput(tag, {31'd0, obs}, {31'd0, exp_last, exp_data});
  endtask

  task automatic applyStimulus(input chacha_word_t d, input logic l);
    int n;
    n = 0;
    msg_valid = 1'b1;
    msg_data  = d;
    msg_last  = l;
    @(negedge clk);
    while (msg_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("msg_accept", {63'd0, msg_ready}, 64'd1);
    @(posedge clk);
    #1;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
  endtask

  task automatic pulseReset();
    reset     = 1'b0;
    msg_valid = 1'b0;
    msg_last  = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    blk_q.delete();
    got_q.delete();
  endtask

  initial begin
    reset     = 1'b0;
    msg_valid = 1'b0;
    msg_data  = '0;
    msg_last  = 1'b0;
    out_ready = 1'b1;

    // Reset state and idle behaviour.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_blk_req",   {63'd0, blk_req},   64'd0);
    checkOutput("rst_blk_ready", {63'd0, blk_ready}, 64'd0);
    checkOutput("rst_msg_ready", {63'd0, msg_ready}, 64'd0);
    checkOutput("rst_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("rst_out_data",  {32'd0, out_data},  64'd0);
    checkOutput("rst_out_last",  {63'd0, out_last},  64'd0);
    checkOutput("rst_busy",      {63'd0, busy},      64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    base  = req_count;
    repeat (5) @(posedge clk);
    @(negedge clk);
    checkOutput("idle_no_req", 64'(req_count - base), 64'd0);
    checkOutput("idle_busy",   {63'd0, busy},         64'd0);

    // Single-word message.
    @(posedge clk);
    #1;
    blk = '0;
    blk[31:0] = 32'h0000_0001;
    blk_q.push_back(blk);
    base = req_count;
    applyStimulus(32'hFFFF_FFFF, 1'b1);
    @(negedge clk);
    checkOutput("t2_out_valid", {63'd0, out_valid}, 64'd1);
    checkOutput("t2_out_data",  {32'd0, out_data},  64'h0000_0000_FFFF_FFFE);
    checkOutput("t2_out_last",  {63'd0, out_last},  64'd1);
    checkOutput("t2_idle",      {63'd0, busy},      64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t2_req",     64'(req_count - base), 64'd1);
    checkOutput("t2_drained", {63'd0, out_valid},    64'd0);
    @(posedge clk);
    #1;

    // 20-word message spanning two blocks.
    pulseReset();
    blk_q.push_back(makeBlock(32'hA000_0000));
    blk_q.push_back(makeBlock(32'hB000_0000));
    base = req_count;
    for (int i = 0; i < 20; i++) applyStimulus(32'h0, i == 19);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t3_count", 64'(got_q.size()), 64'd20);
    for (int i = 0; i < 20; i++)
      checkWord($sformatf("t3_w%0d", i),
                (i < 16) ? 32'hA000_0000 + 32'(i) : 32'hB000_0000 + 32'(i - 16), i == 19);
`ifdef CHACHA_KS_PREFETCH_EN
    checkOutput("t3_req", 64'(req_count - base), 64'd3);
`else
    checkOutput("t3_req", 64'(req_count - base), 64'd2);
`endif

    // Backpressure for 5 cycles in the middle of a block.
    pulseReset();
    blk_q.push_back(makeBlock(32'h5A5A_0000));
    fork
      begin
        for (int i = 0; i < 8; i++) applyStimulus(32'(i) * 32'h0101_0101, i == 7);
      end
      begin
        int n, k;
        n = 0;
        while (got_q.size() < 3 && n < 200) begin
          @(negedge clk);
          n++;
        end
        checkOutput("t4_reach", {63'd0, got_q.size() >= 3}, 64'd1);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        k = got_q.size();
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          checkOutput("t4_msg_ready", {63'd0, msg_ready}, 64'd0);
          checkOutput("t4_hold_valid", {63'd0, out_valid}, 64'd1);
          checkOutput("t4_hold_data", {32'd0, out_data},
                      {32'd0, (32'(k) * 32'h0101_0101) ^ (32'h5A5A_0000 + 32'(k))});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t4_count", 64'(got_q.size()), 64'd8);
    for (int i = 0; i < 8; i++)
      checkWord($sformatf("t4_w%0d", i),
                (32'(i) * 32'h0101_0101) ^ (32'h5A5A_0000 + 32'(i)), i == 7);

    // Reset at word index 7 with an output word still pending.
    pulseReset();
    blk_q.push_back(makeBlock(32'hD000_0000));
    for (int i = 0; i < 7; i++) applyStimulus(32'(i + 1), 1'b0);
    out_ready = 1'b0;
    reset     = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("t5_out_valid", {63'd0, out_valid}, 64'd0);
    checkOutput("t5_out_data",  {32'd0, out_data},  64'd0);
    checkOutput("t5_busy",      {63'd0, busy},      64'd0);
    checkOutput("t5_msg_ready", {63'd0, msg_ready}, 64'd0);
    checkOutput("t5_blk_ready", {63'd0, blk_ready}, 64'd0);
    @(posedge clk);
    #1;
    got_q.delete();
    blk_q.delete();
    blk_q.push_back(makeBlock(32'hE000_0000));
    base = req_count;
    applyStimulus(32'h0, 1'b0);
    applyStimulus(32'h0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5_count", 64'(got_q.size()), 64'd2);
    checkWord("t5_w0", 32'hE000_0000, 1'b0);
    checkWord("t5_w1", 32'hE000_0001, 1'b1);
`ifdef CHACHA_KS_PREFETCH_EN
    checkOutput("t5_req", 64'(req_count - base), 64'd2);
`else
    checkOutput("t5_req", 64'(req_count - base), 64'd1);
`endif

    // 32-word continuous stream: no bubble only when prefetch is built in.
    pulseReset();
    blk_q.push_back(makeBlock(32'h1000_0000));
    blk_q.push_back(makeBlock(32'h2000_0000));
    max_run = 0;
    for (int i = 0; i < 32; i++) applyStimulus(32'(i), i == 31);
    repeat (4) @(posedge clk);
    #1;
`ifdef CHACHA_KS_PREFETCH_EN
    checkOutput("t6_max_run", 64'(max_run), 64'd32);
`else
    checkOutput("t6_max_run", 64'(max_run), 64'd16);
`endif
    checkOutput("t6_count", 64'(got_q.size()), 64'd32);
    for (int i = 0; i < 32; i++)
      checkWord($sformatf("t6_w%0d", i),
                32'(i) ^ ((i < 16) ? 32'h1000_0000 + 32'(i) : 32'h2000_0000 + 32'(i - 16)),
                i == 31);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
